// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared states, BCD limits and BCD increment for the clock front panel
package clk_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_HR = 3'd1,
        ST_SET_MN = 3'd2,
        ST_SET_SD = 3'd3,
        ST_LOAD   = 3'd4,
        ST_ALM_HR = 3'd5,
        ST_ALM_MN = 3'd6
    } state_t;

    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    // One-hot field select, ordered {hr, mn, sd}
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_HR   = 3'b100;
    localparam logic [2:0] SEL_MN   = 3'b010;
    localparam logic [2:0] SEL_SD   = 3'b001;

    // Packed-BCD increment with wrap to 00 past max; out-of-range inputs also wrap
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] res;
        if (val >= max) begin
            res = 8'h00;
        end else if (val[3:0] >= 4'h9) begin
            res = {val[7:4] + 4'h1, 4'h0};
        end else begin
            res = {val[7:4], val[3:0] + 4'h1};
        end
        return res;
    endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - two-flop key synchroniser with rising-edge pulse
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pulse
);

    // sync[0], sync[1] resynchronise; sync[2] holds the previous synchronised level
    logic [2:0] sync;

    // Shift the key level through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1:0], key};
        end
    end

    assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - front-panel set/alarm controller for the BCD clock
module time_set_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter logic [27:0] CNT_MAX   = 28'd50_000_000,
    parameter logic [27:0] BLINK_MAX = 28'd25_000_000,
    parameter logic [7:0]  RING_S    = 8'd60,
    parameter logic [7:0]  TIMEOUT_S = 8'd30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_alarm,
    input  logic [7:0] hr,
    input  logic [7:0] mn,
    input  logic [7:0] sd,
    output logic       set_mod,
    output logic       set_alarm,
    output logic       time_add,
    output logic [7:0] hr_cal,
    output logic [7:0] mn_cal,
    output logic [7:0] sd_cal,
    output logic [7:0] alarm_hr,
    output logic [7:0] alarm_mn,
    output logic       alarm_en,
    output logic       alarm_ring,
    output logic [2:0] blink_sel,
    output logic       blink
);

    state_t      state;
    state_t      state_nxt;
    logic        edge_mode;
    logic        edge_up;
    logic        edge_alarm;
    logic        any_edge;
    logic        ev_mode;
    logic        ev_alarm;
    logic        ev_up;
    logic        in_set;
    logic        in_alm;
    logic        key_acc;
    logic        timeout_hit;
    logic        tick;
    logic        match;
    logic [27:0] tick_cnt;
    logic [27:0] blink_cnt;
    logic [7:0]  timeout_cnt;
    logic [7:0]  ring_cnt;

    key_edge u_key_mode  (.clk(clk), .rst_n(rst_n), .key(key_mode),  .pulse(edge_mode));
    key_edge u_key_up    (.clk(clk), .rst_n(rst_n), .key(key_up),    .pulse(edge_up));
    key_edge u_key_alarm (.clk(clk), .rst_n(rst_n), .key(key_alarm), .pulse(edge_alarm));

    // While ringing, any edge only silences the alarm; otherwise mode > alarm > up
    assign any_edge = edge_mode | edge_up | edge_alarm;
    assign ev_mode  = edge_mode & ~alarm_ring;
    assign ev_alarm = edge_alarm & ~edge_mode & ~alarm_ring;
    assign ev_up    = edge_up & ~edge_mode & ~edge_alarm & ~alarm_ring;

    assign in_set  = (state == ST_SET_HR) || (state == ST_SET_MN) || (state == ST_SET_SD);
    assign in_alm  = (state == ST_ALM_HR) || (state == ST_ALM_MN);
    assign key_acc = (in_set && (ev_mode || ev_up)) || (in_alm && (ev_alarm || ev_up));

    assign tick        = (tick_cnt == CNT_MAX);
    assign timeout_hit = (in_set || in_alm) && tick && !key_acc
                         && (timeout_cnt == TIMEOUT_S - 8'd1);
    assign match       = (hr == alarm_hr) && (mn == alarm_mn) && (sd == 8'h00);

    // Next-state decode; the alarm key is inert in SET_*, the mode key inert in ALM_*
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (ev_mode) begin
                    state_nxt = ST_SET_HR;
                end else if (ev_alarm) begin
                    state_nxt = ST_ALM_HR;
                end
            end
            ST_SET_HR: begin
                if (ev_mode)          state_nxt = ST_SET_MN;
                else if (timeout_hit) state_nxt = ST_RUN;
            end
            ST_SET_MN: begin
                if (ev_mode)          state_nxt = ST_SET_SD;
                else if (timeout_hit) state_nxt = ST_RUN;
            end
            ST_SET_SD: begin
                if (ev_mode)          state_nxt = ST_LOAD;
                else if (timeout_hit) state_nxt = ST_RUN;
            end
            ST_LOAD: state_nxt = ST_RUN;
            ST_ALM_HR: begin
                if (ev_alarm)         state_nxt = ST_ALM_MN;
                else if (timeout_hit) state_nxt = ST_RUN;
            end
            ST_ALM_MN: begin
                if (ev_alarm)         state_nxt = ST_RUN;
                else if (timeout_hit) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            set_mod   <= 1'b0;
            set_alarm <= 1'b0;
            time_add  <= 1'b0;
            blink_sel <= SEL_NONE;
        end else begin
            state     <= state_nxt;
            set_mod   <= state_nxt inside {ST_SET_HR, ST_SET_MN, ST_SET_SD, ST_LOAD};
            set_alarm <= state_nxt inside {ST_ALM_HR, ST_ALM_MN};
            time_add  <= (state_nxt == ST_LOAD);
            case (state_nxt)
                ST_SET_HR, ST_ALM_HR: blink_sel <= SEL_HR;
                ST_SET_MN, ST_ALM_MN: blink_sel <= SEL_MN;
                ST_SET_SD:            blink_sel <= SEL_SD;
                default:              blink_sel <= SEL_NONE;
            endcase
        end
    end

    // Edit registers: snapshot running time on entry, BCD-step the selected field on up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_cal   <= 8'h00;
            mn_cal   <= 8'h00;
            sd_cal   <= 8'h00;
            alarm_hr <= 8'h07;
            alarm_mn <= 8'h00;
        end else if (state == ST_RUN && ev_mode) begin
            hr_cal <= hr;
            mn_cal <= mn;
            sd_cal <= sd;
        end else if (ev_up) begin
            case (state)
                ST_SET_HR: hr_cal   <= bcd_inc(hr_cal, HR_MAX);
                ST_SET_MN: mn_cal   <= bcd_inc(mn_cal, MS_MAX);
                ST_SET_SD: sd_cal   <= bcd_inc(sd_cal, MS_MAX);
                ST_ALM_HR: alarm_hr <= bcd_inc(alarm_hr, HR_MAX);
                ST_ALM_MN: alarm_mn <= bcd_inc(alarm_mn, MS_MAX);
                default: ;
            endcase
        end
    end

    // Free-running 1 s tick divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= 28'd0;
        end else if (tick) begin
            tick_cnt <= 28'd0;
        end else begin
            tick_cnt <= tick_cnt + 28'd1;
        end
    end

    // Blink phase generator, restarted on every state change so a new field starts visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= 28'd0;
            blink     <= 1'b0;
        end else if (state_nxt != state) begin
            blink_cnt <= 28'd0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= 28'd0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 28'd1;
        end
    end

    // Idle-seconds counter for edit states, restarted by each accepted key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= 8'd0;
        end else if (!(in_set || in_alm) || key_acc) begin
            timeout_cnt <= 8'd0;
        end else if (tick) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    // Alarm arm toggle, match detect and ring duration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_en   <= 1'b0;
            alarm_ring <= 1'b0;
            ring_cnt   <= 8'd0;
        end else if (alarm_ring) begin
            if (any_edge || !alarm_en) begin
                alarm_ring <= 1'b0;
            end else if (tick) begin
                if (ring_cnt == RING_S - 8'd1) begin
                    alarm_ring <= 1'b0;
                end else begin
                    ring_cnt <= ring_cnt + 8'd1;
                end
            end
        end else if (state == ST_RUN) begin
            if (ev_up) begin
                alarm_en <= ~alarm_en;
            end else if (alarm_en && match) begin
                alarm_ring <= 1'b1;
                ring_cnt   <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode;
    logic       key_up;
    logic       key_alarm;
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sd;
    logic       set_mod;
    logic       set_alarm;
    logic       time_add;
    logic [7:0] hr_cal;
    logic [7:0] mn_cal;
    logic [7:0] sd_cal;
    logic [7:0] alarm_hr;
    logic [7:0] alarm_mn;
    logic       alarm_en;
    logic       alarm_ring;
    logic [2:0] blink_sel;
    logic       blink;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Expected {hr_cal, mn_cal, sd_cal} at each time_add pulse
    logic [23:0] sb[$];
    logic        ta_prev = 1'b0;

    time_set_ctrl #(
        .CNT_MAX  (28'd9),
        .BLINK_MAX(28'd3),
        .RING_S   (8'd3),
        .TIMEOUT_S(8'd5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_up    (key_up),
        .key_alarm (key_alarm),
        .hr        (hr),
        .mn        (mn),
        .sd        (sd),
        .set_mod   (set_mod),
        .set_alarm (set_alarm),
        .time_add  (time_add),
        .hr_cal    (hr_cal),
        .mn_cal    (mn_cal),
        .sd_cal    (sd_cal),
        .alarm_hr  (alarm_hr),
        .alarm_mn  (alarm_mn),
        .alarm_en  (alarm_en),
        .alarm_ring(alarm_ring),
        .blink_sel (blink_sel),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic m, input logic u, input logic a);
        key_mode  = m;
        key_up    = u;
        key_alarm = a;
        repeat (4) @(negedge clk);
        key_mode  = 1'b0;
        key_up    = 1'b0;
        key_alarm = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hr = h;
        mn = m;
        sd = s;
    endtask

    // Load-strobe monitor: every pulse must be expected, one clk wide, with set_mod high
    always @(negedge clk) begin
        if (time_add === 1'b1) begin
            check("time_add_width", {31'd0, ta_prev}, 32'd0);
            check("time_add_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                check("load_cal", {8'd0, hr_cal, mn_cal, sd_cal}, {8'd0, sb.pop_front()});
                check("load_set_mod", {31'd0, set_mod}, 32'd1);
            end
        end
        ta_prev = time_add;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n     = 1'b0;
        key_mode  = 1'b0;
        key_up    = 1'b0;
        key_alarm = 1'b0;
        set_time(8'h12, 8'h34, 8'h56);
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_set_mod", set_mod, 0);
        check("rst_set_alarm", set_alarm, 0);
        check("rst_time_add", time_add, 0);
        check("rst_cal", {hr_cal, mn_cal, sd_cal}, 0);
        check("rst_alarm", {alarm_hr, alarm_mn}, 32'h0700);
        check("rst_alarm_flags", {alarm_en, alarm_ring}, 0);
        check("rst_blink", {blink_sel, blink}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset in the middle of SET_MN discards the edit
        press(1, 0, 0);
        press(1, 0, 0);
        check("t1_in_set_mn", {set_mod, blink_sel}, 4'b1010);
        rst_n = 1'b0;
        @(negedge clk);
        check("t1_async_clear", {set_mod, blink_sel, hr_cal}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t1_after_rst", {set_mod, set_alarm, blink_sel}, 0);
        check("t1_alarm", {alarm_hr, alarm_mn}, 32'h0700);

        // 2: full time set with hour wrap and second wrap
        set_time(8'h12, 8'h34, 8'h56);
        press(1, 0, 0);
        check("t2_capture", {hr_cal, mn_cal, sd_cal}, 32'h123456);
        check("t2_sel_hr", {set_mod, blink_sel}, 4'b1100);
        for (int i = 0; i < 12; i++) press(0, 1, 0);
        check("t2_hr_wrap", hr_cal, 8'h00);
        press(1, 0, 0);
        press(1, 0, 0);
        check("t2_sel_sd", blink_sel, 3'b001);
        for (int i = 0; i < 5; i++) press(0, 1, 0);
        check("t2_sd", sd_cal, 8'h01);
        sb.push_back(24'h003401);
        press(1, 0, 0);
        check("t2_loaded", sb.size(), 0);
        check("t2_back_run", {set_mod, blink_sel}, 0);

        // 3: x9 carry on hours and 59 wrap on minutes
        set_time(8'h19, 8'h59, 8'h00);
        press(1, 0, 0);
        press(0, 1, 0);
        check("t3_hr_19_20", hr_cal, 8'h20);
        press(1, 0, 0);
        press(0, 1, 0);
        check("t3_mn_59_00", mn_cal, 8'h00);
        press(1, 0, 0);
        sb.push_back(24'h200000);
        press(1, 0, 0);
        check("t3_loaded", sb.size(), 0);

        // 4: alarm edit to 09:01, then arm it from RUN
        press(0, 0, 1);
        check("t4_alm_hr", {set_alarm, set_mod, blink_sel}, 5'b10100);
        press(0, 1, 0);
        press(0, 1, 0);
        check("t4_alarm_hr", {set_alarm, alarm_hr}, 9'h109);
        press(0, 0, 1);
        check("t4_alm_mn", {set_alarm, blink_sel}, 4'b1010);
        press(0, 1, 0);
        check("t4_alarm_mn", {set_alarm, alarm_mn}, 9'h101);
        press(0, 0, 1);
        check("t4_done", {set_alarm, alarm_en, alarm_hr, alarm_mn}, 18'h00901);
        press(0, 1, 0);
        check("t4_armed", alarm_en, 1);

        // 5a: ring on match, self-clears after RING_S ticks
        set_time(8'h09, 8'h00, 8'h59);
        repeat (3) @(negedge clk);
        check("t5_no_ring_early", alarm_ring, 0);
        set_time(8'h09, 8'h01, 8'h00);
        @(negedge clk);
        check("t5_ring_on", alarm_ring, 1);
        set_time(8'h09, 8'h01, 8'h01);
        repeat (18) @(negedge clk);
        check("t5_ring_held", alarm_ring, 1);
        for (k = 0; k < 20 && alarm_ring; k++) @(negedge clk);
        check("t5_ring_cleared", alarm_ring, 0);
        check("t5_ring_clear_time", k <= 12, 1);

        // 5b: a key edge silences the ring without toggling alarm_en
        set_time(8'h09, 8'h00, 8'h59);
        @(negedge clk);
        set_time(8'h09, 8'h01, 8'h00);
        @(negedge clk);
        check("t5b_ring_on", alarm_ring, 1);
        set_time(8'h09, 8'h01, 8'h01);
        press(0, 1, 0);
        check("t5b_key_clear", {alarm_ring, alarm_en}, 2'b01);

        // 6: mode beats up in the same cycle, then idle timeout aborts without a load
        set_time(8'h05, 8'h06, 8'h07);
        press(1, 0, 0);
        check("t6_sel_hr", blink_sel, 3'b100);
        press(1, 1, 0);
        check("t6_mode_wins", {blink_sel, hr_cal}, {3'b010, 8'h05});
        repeat (30) @(negedge clk);
        check("t6_not_yet", set_mod, 1);
        for (k = 0; k < 60 && set_mod; k++) @(negedge clk);
        check("t6_timeout_run", {set_mod, blink_sel}, 0);
        repeat (5) @(negedge clk);
        check("t6_no_pending", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
